mcpu_rom_loader: RTL

Parametrised, download-loaded CPU ROM for the main-CPU subsystem. It generalises the fixed 16 KB, 8-bit ROM window: the size and the download base address are parameters, and the download bus can be 8 or 16 bits wide. In 16-bit mode each download word is split into two byte writes, throttled by `ioctl_wait`. The block also keeps a running checksum and byte count, and raises a `loaded` flag when a download completely fills the window.

---
 rtl/mcpu_rom_loader.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mcpu_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module      : mcpu_rom_loader
//  Description : Download-loaded main-CPU ROM. A 2^AW x 8 RAM is filled from
//                the ioctl download bus (8 or 16 bits wide); 16-bit words are
//                split into two byte writes while ioctl_wait holds the host
//                off. Keeps a mod-256 checksum and a saturating byte count,
//                and flags `loaded` when a download filled the whole window.
//  Ports       : clk_sys, reset_n (async, active low)
//                cpu_ab -> rom_data       CPU read port, 1-cycle latency
//                ioctl_download/addr/dout/wr/wait   download bus
//                loaded, checksum, byte_count       download status
//  Revision    : 1.0  initial release
// ============================================================================
module mcpu_rom_loader #(
    parameter int          AW      = 14,
    parameter logic [26:0] BASE    = 27'h0,
    parameter int          IOCTL_W = 16
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic [AW-1:0] cpu_ab,
    output logic [7:0]    rom_data,
    input  logic          ioctl_download,
    input  logic [26:0]   ioctl_addr,
    input  logic [15:0]   ioctl_dout,
    input  logic          ioctl_wr,
    output logic          ioctl_wait,
    output logic          loaded,
    output logic [7:0]    checksum,
    output logic [AW:0]   byte_count
);

    if (!(IOCTL_W == 8 || IOCTL_W == 16)) begin : g_bad_ioctl_w
        $error("mcpu_rom_loader: IOCTL_W must be 8 or 16");
    end

    localparam logic [1:0]  c_IDLE   = 2'd0;
    localparam logic [1:0]  c_WR_LO  = 2'd1;
    localparam logic [1:0]  c_WR_HI  = 2'd2;
    localparam int          c_DEPTH  = 1 << AW;
    localparam logic [AW:0] c_FULL   = {1'b1, {AW{1'b0}}};
    localparam logic [27:0] c_BASE_X = {1'b0, BASE};
    localparam logic [27:0] c_LIMIT  = c_BASE_X + (28'd1 << AW);

    logic [1:0]    r_state;
    logic [1:0]    w_next;
    logic [AW-1:0] r_off;
    logic [15:0]   r_data;
    logic          r_dl_q;
    logic          r_end_pend;
    logic [7:0]    r_ram [c_DEPTH];

    logic [26:0]   w_addr_al;
    logic [AW-1:0] w_off;
    logic          w_in_win;
    logic          w_accept;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [7:0]    w_wdata;
    logic          w_rise;
    logic          w_fall;
    logic          w_idle_end;
    logic [7:0]    w_sum_base;
    logic [AW:0]   w_cnt_base;

    // Word alignment is applied to the host address before the base is
    // removed, so an odd BASE can place a word straddling the top of the
    // window; that is the only way the high-byte overrun can occur.
    assign w_addr_al = (IOCTL_W == 16) ? {ioctl_addr[26:1], 1'b0} : ioctl_addr;
    assign w_off     = w_addr_al[AW-1:0] - BASE[AW-1:0];
    assign w_in_win  = ({1'b0, ioctl_addr} >= c_BASE_X) &&
                       ({1'b0, ioctl_addr} <  c_LIMIT);
    assign w_accept  = (r_state == c_IDLE) && ioctl_wr && w_in_win;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) r_state <= c_IDLE;
        else          r_state <= w_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (w_accept) w_next = c_WR_LO;
            c_WR_LO: w_next = (IOCTL_W == 16) ? c_WR_HI : c_IDLE;
            c_WR_HI: w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ioctl_wait = 1'b0;
        w_we       = 1'b0;
        w_waddr    = r_off;
        w_wdata    = r_data[7:0];
        case (r_state)
            c_WR_LO: begin
                ioctl_wait = 1'b1;
                w_we       = 1'b1;
            end
            c_WR_HI: begin
                ioctl_wait = 1'b1;
                // No wrap to offset 0: a high byte past the top is dropped.
                w_we       = (r_off != '1);
                w_waddr    = r_off + AW'(1);
                w_wdata    = r_data[15:8];
            end
            default: ;
        endcase
    end

    // Offset and data captured with the accepted strobe.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_off  <= '0;
            r_data <= '0;
        end else if (w_accept) begin
            r_off  <= w_off;
            r_data <= ioctl_dout;
        end
    end

    // Storage: contents survive reset.
    always_ff @(posedge clk_sys) begin
        if (w_we) r_ram[w_waddr] <= w_wdata;
    end

    // Read port; same-address write in the same cycle returns the old byte.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) rom_data <= 8'h00;
        else          rom_data <= ioctl_download ? 8'h00 : r_ram[cpu_ab];
    end

    // ---------------- Download status ----------------
    assign w_rise     = ioctl_download & ~r_dl_q;
    assign w_fall     = ~ioctl_download & r_dl_q;
    assign w_idle_end = (r_state == c_IDLE) && r_end_pend;
    assign w_sum_base = w_rise ? 8'h00 : checksum;
    assign w_cnt_base = w_rise ? '0 : byte_count;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_dl_q     <= 1'b0;
            r_end_pend <= 1'b0;
            loaded     <= 1'b0;
            checksum   <= 8'h00;
            byte_count <= '0;
        end else begin
            r_dl_q     <= ioctl_download;
            checksum   <= w_we ? (w_sum_base + w_wdata) : w_sum_base;
            byte_count <= (w_we && (w_cnt_base != c_FULL)) ?
                          (w_cnt_base + (AW+1)'(1)) : w_cnt_base;
            // End-pending defers the verdict until in-flight bytes land.
            if (w_fall)
                r_end_pend <= 1'b1;
            else if (w_rise || w_idle_end)
                r_end_pend <= 1'b0;
            if (w_rise)
                loaded <= 1'b0;
            else if (w_idle_end)
                loaded <= (byte_count == c_FULL);
        end
    end

endmodule
`default_nettype wire
